mic_frame_buffer: RTL

//  Parametrised successor to the single-window mic sampler. Paces ADC reads with an internal

---
 rtl/mic_frame_buffer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mic_frame_buffer.sv
// Paced ADC sampler with optional averaging, DC removal and saturation into a ring buffer.
// Streams overlapping N-sample frames (hop HOP), oldest sample first, over valid/ready.
module mic_frame_buffer #(
    parameter int CLK_HZ      = 10000000,
    parameter int SAMPLE_RATE = 5000,
    parameter int IN_W        = 12,
    parameter int OUT_W       = 16,
    parameter int N           = 256,
    parameter int HOP         = 128,
    parameter int DECIM       = 1,
    parameter int DC_OFFSET   = 1352
) (
    input  logic                    clk_10MHz,
    input  logic                    rst,
    input  logic [IN_W-1:0]         adc_data,
    input  logic                    enable,
    input  logic                    out_ready,
    input  logic                    clear_overrun,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_last,
    output logic                    overrun,
    output logic                    dbg_state
);

    localparam int DIV   = CLK_HZ / SAMPLE_RATE;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = $clog2(N);
    localparam int DL    = $clog2(DECIM);
    localparam int DCW   = (DL > 0) ? DL : 1;
    localparam int ACC_W = IN_W + DL;
    localparam int CW    = ((IN_W + 1 > OUT_W) ? IN_W + 1 : OUT_W) + 1;
    localparam int HW    = $clog2(N + 1);

    localparam logic [CNT_W-1:0]     DIV_M1    = CNT_W'(DIV - 1);
    localparam logic [DCW-1:0]       DEC_M1    = DCW'(DECIM - 1);
    localparam logic [AW:0]          FILL_FULL = (AW + 1)'(N);
    localparam logic [AW:0]          FILL_LAST = (AW + 1)'(N - 1);
    localparam logic [HW-1:0]        HOP_V     = HW'(HOP);
    localparam logic [AW-1:0]        LAST_IDX  = AW'(N - 1);
    localparam logic signed [CW-1:0] SAT_HI    = CW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [CW-1:0] SAT_LO    = ~SAT_HI;

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        tick_cnt;
    logic                    tick;
    logic [ACC_W-1:0]        acc, acc_sum;
    logic [DCW-1:0]          dec_cnt;
    logic                    sample_done;
    logic [IN_W-1:0]         avg;
    logic signed [CW-1:0]    diff;
    logic [OUT_W-1:0]        sample_v;
    logic [OUT_W-1:0]        mem [N];
    logic [AW-1:0]           wr_ptr, rd_ptr, load_idx, frame_start;
    logic [AW:0]             fill;
    logic [HW-1:0]           hop_cnt, hop_inc;
    logic                    trigger;
    logic                    load;

    assign tick = enable && (tick_cnt == DIV_M1);

    always_ff @(posedge clk_10MHz or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (enable) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    assign acc_sum     = acc + ACC_W'(adc_data);
    assign sample_done = tick && (dec_cnt == DEC_M1);
    assign avg         = IN_W'(acc_sum >> DL);
    assign diff        = $signed(CW'(avg)) - $signed(CW'(DC_OFFSET));

    always_comb begin
        sample_v = diff[OUT_W-1:0];
        if (diff > SAT_HI) begin
            sample_v = SAT_HI[OUT_W-1:0];
        end else if (diff < SAT_LO) begin
            sample_v = SAT_LO[OUT_W-1:0];
        end
    end

    // Accumulator and group count only move on ticks, so enable=0 freezes a partial group.
    always_ff @(posedge clk_10MHz or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            dec_cnt <= '0;
        end else if (tick) begin
            if (sample_done) begin
                acc     <= '0;
                dec_cnt <= '0;
            end else begin
                acc     <= acc_sum;
                dec_cnt <= dec_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_10MHz) begin
        if (sample_done) begin
            mem[wr_ptr] <= sample_v;
        end
    end

    // First frame fires on the N-th write; after that every HOP writes.
    assign hop_inc     = hop_cnt + 1'b1;
    assign trigger     = sample_done && ((fill == FILL_FULL) ? (hop_inc == HOP_V) : (fill == FILL_LAST));
    assign frame_start = wr_ptr + 1'b1;

    always_ff @(posedge clk_10MHz or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            fill    <= '0;
            hop_cnt <= '0;
        end else if (sample_done) begin
            wr_ptr  <= wr_ptr + 1'b1;
            hop_cnt <= trigger ? '0 : hop_inc;
            if (fill != FILL_FULL) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Handshake: a beat transfers on a rising edge with out_valid && out_ready; while
    // out_ready is low, out_valid/out_data/out_last hold. The output register is refilled
    // from the RAM on the transfer edge, giving one sample per cycle.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) state_next = STREAM;
            end
            STREAM: begin
                if (!out_valid) begin
                    load = 1'b1;
                end else if (out_ready) begin
                    if (out_last) state_next = IDLE;
                    else          load       = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_10MHz or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk_10MHz or negedge rst) begin
        if (!rst) begin
            rd_ptr    <= '0;
            load_idx  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state == IDLE && trigger) begin
                rd_ptr   <= frame_start;
                load_idx <= '0;
            end else if (load) begin
                out_data  <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
                load_idx  <= load_idx + 1'b1;
                out_last  <= (load_idx == LAST_IDX);
                out_valid <= 1'b1;
            end else if (state == STREAM && out_valid && out_ready && out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (trigger && state == STREAM) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    assign dbg_state = state;

endmodule
